// File: rtl/uart_periph_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: register
// indices, STATUS bit positions and the transmit FSM state encoding.
package uart_periph_pkg;

  // Register indices decoded from addr_i[3:2]
  localparam logic [1:0] RegTxData = 2'd0;
  localparam logic [1:0] RegStatus = 2'd1;

  // STATUS register bit positions
  localparam int unsigned StatusFullBit     = 0;
  localparam int unsigned StatusEmptyBit    = 1;
  localparam int unsigned StatusBusyBit     = 2;
  localparam int unsigned StatusOverflowBit = 3;

  // Transmit FSM states; PARITY is only entered when parity is built in
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_e;

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte-wide synchronous FIFO feeding the UART serialiser. The head entry is
// visible on rdata_o whenever the FIFO is not empty. Pushes to a full FIFO
// and pops from an empty FIFO are ignored.
module uart_tx_fifo #(
  parameter int Depth = 8
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       push_i,
  input  logic [7:0] wdata_i,
  input  logic       pop_i,
  output logic [7:0] rdata_o,
  output logic       full_o,
  output logic       empty_o
);

  localparam int AW = $clog2(Depth);

  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   count_q;
  logic [7:0]    mem_q [Depth];
  logic          push_ok_s;
  logic          pop_ok_s;

  assign full_o    = (count_q == (AW+1)'(Depth));
  assign empty_o   = (count_q == '0);
  assign push_ok_s = push_i & ~full_o;
  assign pop_ok_s  = pop_i & ~empty_o;
  assign rdata_o   = mem_q[rd_ptr_q];

  // Pointer and occupancy tracking; pointers wrap naturally (power-of-two depth)
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok_s) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage array; contents need no reset because occupancy guards reads
  always_ff @(posedge clk_i) begin
    if (push_ok_s) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/uart_tx_periph.sv
// Memory-mapped UART transmitter (8N1) on the Ibex data bus.
// TXDATA pushes bytes into a FIFO; a baud-rate FSM serialises them on tx_o.
// Build option: define UART_TX_PARITY_EN to insert an even-parity bit
// between the data bits and the stop bit (11-bit frame).
module uart_tx_periph
  import uart_periph_pkg::*;
#(
  parameter int ClockFreqHz = 50000000,
  parameter int BaudRate    = 115200,
  parameter int FifoDepth   = 8
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        gnt_o,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        tx_o
);

  localparam int ClkDiv = ClockFreqHz / BaudRate;
  localparam int CntW   = (ClkDiv > 1) ? $clog2(ClkDiv) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(ClkDiv - 1);

  // Bus side
  logic        rvalid_q;
  logic [31:0] rdata_q;
  logic [31:0] rdata_d;
  logic        overflow_q;
  logic        overflow_d;
  logic        push_s;
  logic        ovf_clr_s;
  logic [31:0] status_s;

  // FIFO side
  logic        pop_s;
  logic [7:0]  fifo_rdata_s;
  logic        fifo_full_s;
  logic        fifo_empty_s;

  // Serialiser
  tx_state_e      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            tx_q, tx_d;
  logic            adv_s;
`ifdef UART_TX_PARITY_EN
  logic            par_q, par_d;
`endif

  logic unused_s;
  assign unused_s = ^{be_i[3:1], addr_i[31:4], addr_i[1:0], wdata_i[31:8], wdata_i[2:0]};

  // ---------------------------------------------------------------------
  // Bus interface and register map
  // ---------------------------------------------------------------------
  assign gnt_o    = req_i;
  assign rvalid_o = rvalid_q;
  assign rdata_o  = rdata_q;

  assign push_s    = req_i & we_i & (addr_i[3:2] == RegTxData) & be_i[0];
  assign ovf_clr_s = req_i & we_i & (addr_i[3:2] == RegStatus) & be_i[0] & wdata_i[3];

  // STATUS word assembled from live FIFO/FSM state
  always_comb begin
    status_s                    = 32'h0000_0000;
    status_s[StatusFullBit]     = fifo_full_s;
    status_s[StatusEmptyBit]    = fifo_empty_s;
    status_s[StatusBusyBit]     = (state_q != IDLE);
    status_s[StatusOverflowBit] = overflow_q;
  end

  // Read data mux and sticky overflow update
  always_comb begin
    rdata_d = 32'h0000_0000;
    if (req_i && !we_i) begin
      case (addr_i[3:2])
        RegStatus: rdata_d = status_s;
        default:   rdata_d = 32'h0000_0000;
      endcase
    end else begin
      rdata_d = 32'h0000_0000;
    end

    overflow_d = overflow_q;
    if (push_s && fifo_full_s) begin
      overflow_d = 1'b1;
    end else if (ovf_clr_s) begin
      overflow_d = 1'b0;
    end else begin
      overflow_d = overflow_q;
    end
  end

  // Response registers: one-cycle response to every granted request
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rvalid_q   <= 1'b0;
      rdata_q    <= 32'h0000_0000;
      overflow_q <= 1'b0;
    end else begin
      rvalid_q   <= req_i;
      rdata_q    <= rdata_d;
      overflow_q <= overflow_d;
    end
  end

  // ---------------------------------------------------------------------
  // TX FIFO
  // ---------------------------------------------------------------------
  assign pop_s = (state_q == IDLE) & ~fifo_empty_s;

  uart_tx_fifo #(
    .Depth(FifoDepth)
  ) u_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .push_i (push_s),
    .wdata_i(wdata_i[7:0]),
    .pop_i  (pop_s),
    .rdata_o(fifo_rdata_s),
    .full_o (fifo_full_s),
    .empty_o(fifo_empty_s)
  );

  // ---------------------------------------------------------------------
  // Serialiser FSM
  // ---------------------------------------------------------------------
  assign adv_s = (cnt_q == CntMax);
  assign tx_o  = tx_q;

  // State register plus datapath registers of the serialiser
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= 3'd0;
      shift_q <= 8'h00;
      tx_q    <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  // Next-state logic: baud counter, bit index and shift register
  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    shift_d = shift_q;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      IDLE: begin
        if (!fifo_empty_s) begin
          state_d = START;
          shift_d = fifo_rdata_s;
          bit_d   = 3'd0;
`ifdef UART_TX_PARITY_EN
          par_d   = ^fifo_rdata_s;
`endif
        end else begin
          state_d = IDLE;
        end
      end
      START: begin
        if (adv_s) begin
          state_d = DATA;
        end else begin
          state_d = START;
        end
      end
      DATA: begin
        if (adv_s) begin
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          state_d = DATA;
        end
      end
      PARITY: begin
        if (adv_s) begin
          state_d = STOP;
        end else begin
          state_d = PARITY;
        end
      end
      STOP: begin
        if (adv_s) begin
          state_d = IDLE;
        end else begin
          state_d = STOP;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Counter restarts on every state change and at each bit boundary
    if ((state_d != state_q) || adv_s || (state_q == IDLE)) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  // Output logic: line level for the upcoming cycle, registered into tx_q
  always_comb begin
    case (state_d)
      IDLE:    tx_d = 1'b1;
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_d = par_d;
`else
      PARITY:  tx_d = 1'b1;
`endif
      STOP:    tx_d = 1'b1;
      default: tx_d = 1'b1;
    endcase
  end

endmodule
